// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue: tag allocation, CDB capture, commit, mispredict flush (optional macro ROB_CDB_BYPASS_EN)
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] rob_issue_idx,
    input  logic                 issue_rdy,
    input  logic [4:0]           issue_rd_id,
    input  logic                 issue_is_branch,
    input  logic                 issue_is_store,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_alt_pc,
    input  logic                 issue_ready,
    input  logic [31:0]          issue_val,
    input  logic [ROB_WIDTH-1:0] iu_to_rob_rs1_depend,
    output logic                 rob_to_iu_rs1_ready,
    output logic [31:0]          rob_to_iu_rs1_val,
    input  logic [ROB_WIDTH-1:0] iu_to_rob_rs2_depend,
    output logic                 rob_to_iu_rs2_ready,
    output logic [31:0]          rob_to_iu_rs2_val,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob_idx,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_taken,
    output logic                 rob_to_rf_commit,
    output logic [4:0]           rob_to_rf_reg_id,
    output logic [31:0]          rob_to_rf_reg_val,
    output logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx,
    output logic                 rob_to_lsb_store_commit,
    output logic                 clr_out,
    output logic [31:0]          clr_pc
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] TAG_NONE  = '0;
    localparam logic [ROB_WIDTH-1:0] TAG_ONE   = ROB_WIDTH'(1);
    // Capacity is 2^W-1, which is also the highest tag and the full count.
    localparam logic [ROB_WIDTH-1:0] TAG_LAST  = {ROB_WIDTH{1'b1}};

    // Entry storage indexed by tag; slot 0 exists only so the tag indexes directly.
    logic        r_valid     [DEPTH];
    logic        r_ready     [DEPTH];
    logic [31:0] r_val       [DEPTH];
    logic [4:0]  r_rd        [DEPTH];
    logic        r_is_branch [DEPTH];
    logic        r_is_store  [DEPTH];
    logic        r_pred      [DEPTH];
    logic        r_taken     [DEPTH];
    logic [31:0] r_alt_pc    [DEPTH];

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH-1:0] r_count;

    logic                 r_commit;
    logic [4:0]           r_reg_id;
    logic [31:0]          r_reg_val;
    logic [ROB_WIDTH-1:0] r_rob_idx;
    logic                 r_store_commit;
    logic                 r_clr;
    logic [31:0]          r_clr_pc;

    logic w_full;
    logic w_issue;
    logic w_cdb_hit;
    logic w_commit;
    logic w_mispredict;

    function automatic logic [ROB_WIDTH-1:0] f_next_tag(input logic [ROB_WIDTH-1:0] tag);
        return (tag == TAG_LAST) ? TAG_ONE : tag + TAG_ONE;
    endfunction

    // The clear cycle swallows issue and CDB traffic that belongs to the flushed path.
    assign w_full       = (r_count == TAG_LAST);
    assign w_issue      = issue_rdy && !w_full && !r_clr;
    assign w_cdb_hit    = cdb_valid && !r_clr && (cdb_rob_idx != TAG_NONE) && r_valid[cdb_rob_idx];
    assign w_commit     = r_valid[r_head] && r_ready[r_head];
    assign w_mispredict = w_commit && r_is_branch[r_head] && (r_taken[r_head] != r_pred[r_head]);

    assign rob_full                = w_full;
    assign rob_issue_idx           = r_tail;
    assign rob_to_rf_commit        = r_commit;
    assign rob_to_rf_reg_id        = r_reg_id;
    assign rob_to_rf_reg_val       = r_reg_val;
    assign rob_to_rf_rob_idx       = r_rob_idx;
    assign rob_to_lsb_store_commit = r_store_commit;
    assign clr_out                 = r_clr;
    assign clr_pc                  = r_clr_pc;

    // Entry state: retire head, capture CDB results, allocate at tail; a flush wipes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
            end
            if (w_cdb_hit) begin
                r_ready[cdb_rob_idx] <= 1'b1;
                r_val[cdb_rob_idx]   <= cdb_val;
                r_taken[cdb_rob_idx] <= cdb_taken;
            end
            if (w_issue) begin
                r_valid[r_tail]     <= 1'b1;
                r_ready[r_tail]     <= issue_ready;
                r_val[r_tail]       <= issue_val;
                r_rd[r_tail]        <= issue_rd_id;
                r_is_branch[r_tail] <= issue_is_branch;
                r_is_store[r_tail]  <= issue_is_store;
                r_pred[r_tail]      <= issue_pred_taken;
                // An entry resolved at issue carries no prediction to contradict.
                r_taken[r_tail]     <= issue_pred_taken;
                r_alt_pc[r_tail]    <= issue_alt_pc;
            end
            if (w_mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_valid[i] <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
            end
        end
    end

    // Head/tail pointers walk 1..N and wrap; occupancy tracks issue minus commit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= TAG_ONE;
            r_tail  <= TAG_ONE;
            r_count <= TAG_NONE;
        end else if (rdy_in) begin
            if (w_mispredict) begin
                r_head  <= TAG_ONE;
                r_tail  <= TAG_ONE;
                r_count <= TAG_NONE;
            end else begin
                if (w_commit) begin
                    r_head <= f_next_tag(r_head);
                end
                if (w_issue) begin
                    r_tail <= f_next_tag(r_tail);
                end
                case ({w_issue, w_commit})
                    2'b10:   r_count <= r_count + TAG_ONE;
                    2'b01:   r_count <= r_count - TAG_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Registered commit and flush ports; pulses drop unless refreshed, data holds.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_commit       <= 1'b0;
            r_reg_id       <= 5'd0;
            r_reg_val      <= 32'd0;
            r_rob_idx      <= TAG_NONE;
            r_store_commit <= 1'b0;
            r_clr          <= 1'b0;
            r_clr_pc       <= 32'd0;
        end else if (rdy_in) begin
            r_commit       <= 1'b0;
            r_store_commit <= 1'b0;
            r_clr          <= 1'b0;
            if (w_commit) begin
                r_commit       <= (r_rd[r_head] != 5'd0);
                r_reg_id       <= r_rd[r_head];
                r_reg_val      <= r_val[r_head];
                r_rob_idx      <= r_head;
                r_store_commit <= r_is_store[r_head];
            end
            if (w_mispredict) begin
                r_clr    <= 1'b1;
                r_clr_pc <= r_alt_pc[r_head];
            end
        end
    end

    // rs1 operand lookup; tag 0 means the operand has no producer.
    always_comb begin
        rob_to_iu_rs1_ready = r_ready[iu_to_rob_rs1_depend];
        rob_to_iu_rs1_val   = r_val[iu_to_rob_rs1_depend];
        if (iu_to_rob_rs1_depend == TAG_NONE) begin
            rob_to_iu_rs1_ready = 1'b1;
            rob_to_iu_rs1_val   = 32'd0;
        end
`ifdef ROB_CDB_BYPASS_EN
        else if (cdb_valid && (cdb_rob_idx == iu_to_rob_rs1_depend)) begin
            rob_to_iu_rs1_ready = 1'b1;
            rob_to_iu_rs1_val   = cdb_val;
        end
`endif
    end

    // rs2 operand lookup, same rules as rs1.
    always_comb begin
        rob_to_iu_rs2_ready = r_ready[iu_to_rob_rs2_depend];
        rob_to_iu_rs2_val   = r_val[iu_to_rob_rs2_depend];
        if (iu_to_rob_rs2_depend == TAG_NONE) begin
            rob_to_iu_rs2_ready = 1'b1;
            rob_to_iu_rs2_val   = 32'd0;
        end
`ifdef ROB_CDB_BYPASS_EN
        else if (cdb_valid && (cdb_rob_idx == iu_to_rob_rs2_depend)) begin
            rob_to_iu_rs2_ready = 1'b1;
            rob_to_iu_rs2_val   = cdb_val;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized checks of reorder_buffer against a queue model
module tb_reorder_buffer;
    localparam int W = 3;
    localparam int N = 7;

    logic         clk_in = 1'b0;
    logic         rst_in, rdy_in;
    logic         rob_full;
    logic [W-1:0] rob_issue_idx;
    logic         issue_rdy, issue_is_branch, issue_is_store, issue_pred_taken, issue_ready;
    logic [4:0]   issue_rd_id;
    logic [31:0]  issue_alt_pc, issue_val;
    logic [W-1:0] rs1_dep, rs2_dep;
    logic         rs1_ready, rs2_ready;
    logic [31:0]  rs1_val, rs2_val;
    logic         cdb_valid, cdb_taken;
    logic [W-1:0] cdb_rob_idx;
    logic [31:0]  cdb_val;
    logic         rf_commit, store_commit, clr_out;
    logic [4:0]   rf_reg_id;
    logic [31:0]  rf_reg_val, clr_pc;
    logic [W-1:0] rf_rob_idx;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .rob_issue_idx(rob_issue_idx),
        .issue_rdy(issue_rdy), .issue_rd_id(issue_rd_id), .issue_is_branch(issue_is_branch),
        .issue_is_store(issue_is_store), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .issue_ready(issue_ready), .issue_val(issue_val),
        .iu_to_rob_rs1_depend(rs1_dep), .rob_to_iu_rs1_ready(rs1_ready), .rob_to_iu_rs1_val(rs1_val),
        .iu_to_rob_rs2_depend(rs2_dep), .rob_to_iu_rs2_ready(rs2_ready), .rob_to_iu_rs2_val(rs2_val),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
        .rob_to_rf_commit(rf_commit), .rob_to_rf_reg_id(rf_reg_id), .rob_to_rf_reg_val(rf_reg_val),
        .rob_to_rf_rob_idx(rf_rob_idx), .rob_to_lsb_store_commit(store_commit),
        .clr_out(clr_out), .clr_pc(clr_pc)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Program-order model: the queue front is the oldest in-flight instruction.
    typedef struct packed {
        logic [W-1:0] tag;
        logic [4:0]   rd;
        logic         br, st, pred, taken, rdy;
        logic [31:0]  alt, val;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] m_next   = 1;
    logic         m_clr    = 0, m_commit = 0, m_store = 0;
    logic [31:0]  m_clr_pc = 0, m_val = 0;
    logic [4:0]   m_rd     = 0;
    logic [W-1:0] m_idx    = 0;

    task automatic model_step();
        ent_t h, e;
        bit   com, mis, was_full, prev_clr;
        if (rst_in) begin
            q.delete();
            m_next = 1; m_clr = 0; m_clr_pc = 0; m_commit = 0; m_store = 0;
            m_val = 0; m_rd = 0; m_idx = 0;
            return;
        end
        if (!rdy_in) return;
        was_full = (q.size() == N);
        com      = (q.size() > 0) && q[0].rdy;
        mis      = 0;
        prev_clr = m_clr;
        m_commit = 0; m_store = 0; m_clr = 0;
        if (com) begin
            h = q.pop_front();
            m_commit = (h.rd != 0); m_store = h.st; m_rd = h.rd; m_val = h.val; m_idx = h.tag;
            mis = h.br && (h.taken != h.pred);
        end
        if (mis) begin
            q.delete();
            m_next = 1; m_clr = 1; m_clr_pc = h.alt;
            return;
        end
        if (!prev_clr && cdb_valid)
            foreach (q[i]) if (q[i].tag == cdb_rob_idx) begin
                q[i].rdy = 1; q[i].val = cdb_val; q[i].taken = cdb_taken;
            end
        if (!prev_clr && issue_rdy && !was_full) begin
            e.tag = m_next; e.rd = issue_rd_id; e.br = issue_is_branch; e.st = issue_is_store;
            e.pred = issue_pred_taken; e.taken = issue_pred_taken; e.rdy = issue_ready;
            e.alt = issue_alt_pc; e.val = issue_val;
            q.push_back(e);
            m_next = (m_next == W'(N)) ? W'(1) : m_next + W'(1);
        end
    endtask

    task automatic check_lookup(input string tag, input logic [W-1:0] dep,
                                input logic got_rdy, input logic [31:0] got_val);
        bit          known = 0;
        logic        er    = 0;
        logic [31:0] ev    = 0;
        if (dep == 0) begin known = 1; er = 1; ev = 0; end
        else foreach (q[i]) if (q[i].tag == dep) begin known = 1; er = q[i].rdy; ev = q[i].val; end
`ifdef ROB_CDB_BYPASS_EN
        if (dep != 0 && cdb_valid && cdb_rob_idx == dep) begin known = 1; er = 1; ev = cdb_val; end
`endif
        if (known) begin
            check_eq({tag, "_ready"}, 32'(got_rdy), 32'(er));
            if (er) check_eq({tag, "_val"}, got_val, ev);
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        #1;
        if (!rst_in) begin
            check_eq("full", 32'(rob_full), 32'(q.size() == N));
            check_eq("issue_idx", 32'(rob_issue_idx), 32'(m_next));
            check_lookup("rs1", rs1_dep, rs1_ready, rs1_val);
            check_lookup("rs2", rs2_dep, rs2_ready, rs2_val);
        end
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        check_eq("commit", 32'(rf_commit), 32'(m_commit));
        check_eq("reg_id", 32'(rf_reg_id), 32'(m_rd));
        check_eq("reg_val", rf_reg_val, m_val);
        check_eq("rob_idx", 32'(rf_rob_idx), 32'(m_idx));
        check_eq("store_commit", 32'(store_commit), 32'(m_store));
        check_eq("clr_out", 32'(clr_out), 32'(m_clr));
        check_eq("clr_pc", clr_pc, m_clr_pc);
    endtask

    task automatic idle_inputs();
        rst_in = 0; rdy_in = 1; issue_rdy = 0; issue_rd_id = 0; issue_is_branch = 0;
        issue_is_store = 0; issue_pred_taken = 0; issue_alt_pc = 0; issue_ready = 0;
        issue_val = 0; rs1_dep = 0; rs2_dep = 0; cdb_valid = 0; cdb_rob_idx = 0;
        cdb_val = 0; cdb_taken = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic br, input logic [31:0] alt);
        issue_rdy = 1; issue_rd_id = rd; issue_is_branch = br; issue_alt_pc = alt;
        issue_pred_taken = 0; issue_ready = 0; issue_val = 0;
    endtask

    task automatic set_cdb(input logic [W-1:0] tag, input logic [31:0] v, input logic tk);
        cdb_valid = 1; cdb_rob_idx = tag; cdb_val = v; cdb_taken = tk;
    endtask

    task automatic do_reset();
        idle_inputs(); rst_in = 1; tick(); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk_in);

        do_reset();
        check_eq("rst_issue_idx", 32'(rob_issue_idx), 32'd1);
        check_eq("rst_full", 32'(rob_full), 32'd0);
        check_eq("rst_commit", 32'(rf_commit), 32'd0);
        check_eq("rst_clr", 32'(clr_out), 32'd0);

        // Fill to capacity, try an 8th issue, then free the head and reuse tag 1.
        for (int i = 0; i < N; i++) begin idle_inputs(); set_issue(5'(i + 1), 0, 0); tick(); end
        check_eq("fill_full", 32'(rob_full), 32'd1);
        idle_inputs(); set_issue(5'd9, 0, 0); tick();
        check_eq("full_ignored_idx", 32'(rob_issue_idx), 32'd1);
        idle_inputs(); set_cdb(3'd1, 32'h55, 0); tick();
        idle_inputs(); tick();
        check_eq("freed_commit_rd", 32'(rf_reg_id), 32'd1);
        check_eq("freed_full", 32'(rob_full), 32'd0);
        idle_inputs(); set_issue(5'd10, 0, 0); tick();
        check_eq("wrap_idx", 32'(rob_issue_idx), 32'd2);
        check_eq("wrap_full", 32'(rob_full), 32'd1);

        // Single result commits with its register and value.
        do_reset();
        set_issue(5'd5, 0, 0); tick();
        idle_inputs(); set_cdb(3'd1, 32'h1234, 0); tick();
        idle_inputs(); tick();
        check_eq("c1_commit", 32'(rf_commit), 32'd1);
        check_eq("c1_reg", 32'(rf_reg_id), 32'd5);
        check_eq("c1_val", rf_reg_val, 32'h1234);
        check_eq("c1_idx", 32'(rf_rob_idx), 32'd1);
        tick();
        check_eq("c1_pulse_drop", 32'(rf_commit), 32'd0);

        // Out-of-order completion still retires in order, back to back.
        do_reset();
        set_issue(5'd3, 0, 0); tick();
        idle_inputs(); set_issue(5'd4, 0, 0); tick();
        idle_inputs(); set_cdb(3'd2, 32'h22, 0); tick();
        idle_inputs(); tick();
        check_eq("ooo_no_commit", 32'(rf_commit), 32'd0);
        set_cdb(3'd1, 32'h11, 0); tick();
        idle_inputs(); tick();
        check_eq("ooo_first_idx", 32'(rf_rob_idx), 32'd1);
        tick();
        check_eq("ooo_second_commit", 32'(rf_commit), 32'd1);
        check_eq("ooo_second_idx", 32'(rf_rob_idx), 32'd2);
        check_eq("ooo_second_val", rf_reg_val, 32'h22);

        // Mispredicted branch at head flushes; CDB and issue in the clear cycle are dropped.
        do_reset();
        set_issue(5'd1, 1, 32'h100); tick();
        idle_inputs(); set_issue(5'd7, 0, 0); tick();
        idle_inputs(); set_cdb(3'd1, 32'h44, 1); tick();
        idle_inputs(); tick();
        check_eq("mp_clr", 32'(clr_out), 32'd1);
        check_eq("mp_clr_pc", clr_pc, 32'h100);
        check_eq("mp_link_commit", 32'(rf_commit), 32'd1);
        check_eq("mp_idx", 32'(rob_issue_idx), 32'd1);
        check_eq("mp_full", 32'(rob_full), 32'd0);
        set_cdb(3'd2, 32'h77, 0); set_issue(5'd8, 0, 0); tick();
        check_eq("mp_clr_drop", 32'(clr_out), 32'd0);
        check_eq("mp_issue_ignored", 32'(rob_issue_idx), 32'd1);
        idle_inputs(); tick();
        check_eq("mp_no_commit", 32'(rf_commit), 32'd0);

        // Operand lookup while the producing result is on the CDB.
        do_reset();
        for (int i = 0; i < 3; i++) begin idle_inputs(); set_issue(5'(i + 1), 0, 0); tick(); end
        idle_inputs(); set_cdb(3'd3, 32'hAA, 0); rs1_dep = 3'd3;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check_eq("bypass_ready", 32'(rs1_ready), 32'd1);
        check_eq("bypass_val", rs1_val, 32'hAA);
`else
        check_eq("nobypass_ready", 32'(rs1_ready), 32'd0);
`endif
        tick();
        idle_inputs(); rs2_dep = 3'd3;
        #1;
        check_eq("stored_ready", 32'(rs2_ready), 32'd1);
        check_eq("stored_val", rs2_val, 32'hAA);
        tick();

        // Issue together with commit keeps occupancy, then a three-cycle freeze holds outputs.
        do_reset();
        for (int i = 0; i < 6; i++) begin idle_inputs(); set_issue(5'(i + 1), 0, 0); tick(); end
        idle_inputs(); set_cdb(3'd1, 32'h99, 0); tick();
        idle_inputs(); set_issue(5'd20, 0, 0); tick();
        check_eq("ic_commit", 32'(rf_commit), 32'd1);
        check_eq("ic_full", 32'(rob_full), 32'd0);
        check_eq("ic_idx", 32'(rob_issue_idx), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); rdy_in = 0; set_issue(5'd21, 0, 0); set_cdb(3'd2, 32'h5, 0); tick();
            check_eq("frz_commit", 32'(rf_commit), 32'd1);
            check_eq("frz_idx", 32'(rob_issue_idx), 32'd1);
        end
        idle_inputs(); set_issue(5'd22, 0, 0); tick();
        check_eq("refill_full", 32'(rob_full), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            rst_in           = ($urandom_range(0, 499) == 0);
            rdy_in           = ($urandom_range(0, 9) != 0);
            issue_rdy        = ($urandom_range(0, 2) != 0);
            issue_rd_id      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue_is_branch  = ($urandom_range(0, 7) == 0);
            issue_is_store   = ($urandom_range(0, 7) == 0);
            issue_pred_taken = 1'($urandom);
            issue_alt_pc     = $urandom;
            issue_ready      = !issue_is_branch && ($urandom_range(0, 3) == 0);
            issue_val        = $urandom;
            cdb_valid        = ($urandom_range(0, 1) == 0);
            if (q.size() > 0 && $urandom_range(0, 9) < 7)
                cdb_rob_idx = q[$urandom_range(0, q.size() - 1)].tag;
            else
                cdb_rob_idx = W'($urandom_range(0, N));
            cdb_val   = $urandom;
            cdb_taken = 1'($urandom);
            rs1_dep   = W'($urandom_range(0, N));
            rs2_dep   = W'($urandom_range(0, N));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
